// File: rtl/card_match_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : card_match_judge                                                |
// | Purpose  : Judges a keypad card pick against the tile ahead of the chicken,|
// |            times the reveal window and tracks chicken progress to the goal. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module card_match_judge #(
  parameter int NCARDS     = 12,
  parameter int NPIC       = 6,
  parameter int TRACK_LEN  = 24,
  parameter int PIC_STEP   = 5,
  parameter int GOAL_STEPS = 30,
  parameter int REVEAL_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       arm,
  input  logic       adv,
  output logic       c,
  output logic       go,
  output logic       win,
  output logic [4:0] pos,
  output logic [2:0] face,
  output logic       busy
);

  localparam int         SW          = $clog2(GOAL_STEPS + 1);
  localparam int         TW          = (REVEAL_CYC > 1) ? $clog2(REVEAL_CYC) : 1;
  localparam logic [2:0] C_AHEAD_RST = 3'(PIC_STEP % NPIC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOK   = 2'd1,
    S_REVEAL = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_idx;
  logic              r_match;
  logic [TW-1:0]     r_timer;
  logic [NCARDS-1:0] r_used;
  logic [SW-1:0]     r_steps;
  logic [2:0]        r_ahead;

  logic [3:0]  w_idx;
  logic        w_key_ok;
  logic [15:0] w_used_ext;
  logic        w_accept;
  logic [2:0]  w_pic;
  logic        w_adv_ok;
  logic [3:0]  w_ahead_sum;
  logic [2:0]  w_ahead_next;
  logic [4:0]  w_pos_next;
  logic [SW-1:0] w_steps_inc;

  assign w_idx        = key - 4'd1;
  assign w_key_ok     = (key != 4'd0) && (key <= 4'(NCARDS));
  assign w_used_ext   = 16'(r_used);
  assign w_accept     = key_valid & arm & w_key_ok & ~w_used_ext[w_idx] & ~win;
  assign w_pic        = 3'(w_idx % 4'(NPIC));
  assign w_adv_ok     = adv & go & ~win;
  assign w_ahead_sum  = 4'({1'b0, r_ahead}) + 4'(PIC_STEP);
  assign w_ahead_next = (w_ahead_sum >= 4'(NPIC)) ? 3'(w_ahead_sum - 4'(NPIC)) : 3'(w_ahead_sum);
  assign w_pos_next   = (pos == 5'(TRACK_LEN - 1)) ? 5'd0 : pos + 5'd1;
  assign w_steps_inc  = r_steps + SW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_match <= 1'b0;
      r_timer <= '0;
      r_used  <= '0;
      r_steps <= '0;
      r_ahead <= C_AHEAD_RST;
      c       <= 1'b0;
      go      <= 1'b0;
      win     <= 1'b0;
      pos     <= 5'd0;
      face    <= 3'd0;
      busy    <= 1'b0;
    end else begin
      c <= 1'b0;

      // Consuming go here guarantees one advance per successful match.
      if (w_adv_ok) begin
        pos     <= w_pos_next;
        r_ahead <= w_ahead_next;
        r_steps <= w_steps_inc;
        go      <= 1'b0;
        if (w_steps_inc == SW'(GOAL_STEPS)) begin
          win <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            face    <= w_pic;
            busy    <= 1'b1;
            go      <= 1'b0;
            r_state <= S_LOOK;
          end
        end
        S_LOOK: begin
          r_match <= (face == r_ahead);
          r_timer <= TW'(REVEAL_CYC - 1);
          r_state <= S_REVEAL;
        end
        S_REVEAL: begin
          if (r_timer == '0) begin
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_DONE: begin
          c       <= 1'b1;
          go      <= r_match;
          busy    <= 1'b0;
          // A miss ends the turn and frees every card again.
          if (r_match) begin
            r_used <= r_used | (NCARDS'(1) << r_idx);
          end else begin
            r_used <= '0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_card_match_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_card_match_judge                                             |
// | Purpose  : Directed bench with a result-pulse scoreboard for the judge.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_card_match_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       key_valid;
  logic       arm;
  logic       adv;
  logic       c;
  logic       go;
  logic       win;
  logic [4:0] pos;
  logic [2:0] face;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic go;
    int   cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model of the judge's architectural state.
  bit [11:0] m_used;
  int        m_ahead;
  int        m_pos;
  int        m_steps;
  bit        m_win;
  bit        m_go;

  card_match_judge dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .arm       (arm),
    .adv       (adv),
    .c         (c),
    .go        (go),
    .win       (win),
    .pos       (pos),
    .face      (face),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result monitor: every c pulse must match the oldest outstanding pick.
  always @(negedge clk) begin
    if (rst === 1'b1 && c === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_c: got c=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (go !== e.go) begin
          n_err++;
          $display("FAIL result_go: got %0b, expected %0b", go, e.go);
        end
        n_checks++;
        if (cyc != e.cyc) begin
          n_err++;
          $display("FAIL result_latency: got c at cycle %0d, expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic model_reset();
    m_used  = '0;
    m_ahead = 5;
    m_pos   = 0;
    m_steps = 0;
    m_win   = 1'b0;
    m_go    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_c"},    32'(c),    32'd0);
    chk({tag, "_go"},   32'(go),   32'd0);
    chk({tag, "_win"},  32'(win),  32'd0);
    chk({tag, "_pos"},  32'(pos),  32'd0);
    chk({tag, "_face"}, 32'(face), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pick(input int k, input bit wait_done);
    bit accept;
    int pic;
    int n;
    @(negedge clk);
    key       = 4'(k);
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    accept = arm && (k >= 1) && (k <= 12) && !m_used[k-1] && !m_win;
    chk("pick_busy", 32'(busy), 32'(accept));
    if (accept) begin
      exp_t e;
      pic = (k - 1) % 6;
      chk("pick_face", 32'(face), 32'(pic));
      e.go  = (pic == m_ahead);
      e.cyc = cyc + 10;
      sb.push_back(e);
      m_go = 1'b0;
      if (wait_done) begin
        n = 0;
        while (busy === 1'b1 && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("pick_timeout", 32'(busy), 32'd0);
        m_go = e.go;
        if (e.go) m_used[k-1] = 1'b1;
        else      m_used = '0;
      end
    end
  endtask

  task automatic adv_pulse();
    @(negedge clk);
    adv = 1'b1;
    @(posedge clk);
    #1;
    if (m_go && !m_win) begin
      m_pos   = (m_pos == 23) ? 0 : m_pos + 1;
      m_ahead = (m_ahead + 5) % 6;
      m_steps++;
      if (m_steps == 30) m_win = 1'b1;
    end
    m_go = 1'b0;
    chk("adv_pos", 32'(pos), 32'(m_pos));
    chk("adv_go",  32'(go),  32'(m_go));
    chk("adv_win", 32'(win), 32'(m_win));
    @(negedge clk);
    adv = 1'b0;
  endtask

  // Pick the card showing the tile-ahead picture, then advance once.
  task automatic match_step();
    int p;
    p = m_ahead;
    if ($countones(m_used) >= 6) begin
      for (int j = 1; j <= 12; j++) begin
        if (!m_used[j-1] && ((j - 1) % 6) != p) begin
          pick(j, 1'b1);
          break;
        end
      end
    end
    pick(!m_used[p] ? p + 1 : p + 7, 1'b1);
    chk("match_go", 32'(go), 32'd1);
    adv_pulse();
  endtask

  initial begin
    rst = 1'b0; key = 4'd0; key_valid = 1'b0; arm = 1'b0; adv = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    arm = 1'b1;

    // Card 6 (pic 5) against tile 1 (pic 5).
    pick(6, 1'b1);
    chk("t1_go", 32'(go), 32'd1);

    adv_pulse();
    pick(6, 1'b1);

    // Card 1 (pic 0) against pic 4: miss, advance ignored, mask cleared.
    pick(1, 1'b1);
    chk("t3_go", 32'(go), 32'd0);
    adv_pulse();
    pick(6, 1'b1);

    pick(0, 1'b1);
    pick(13, 1'b1);
    pick(15, 1'b1);
    arm = 1'b0;
    pick(2, 1'b1);
    arm = 1'b1;

    while (m_steps < 29) begin
      match_step();
      if (m_steps == 24) chk("pos_wrap", 32'(pos), 32'd0);
    end
    match_step();
    chk("win_set", 32'(win), 32'd1);
    pick(m_ahead + 1, 1'b1);
    adv_pulse();
    chk("win_pos_hold", 32'(pos), 32'd6);

    // Reset aborts a reveal in progress.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    model_reset();
    check_all_zero("rst_win");
    @(negedge clk);
    rst = 1'b1;
    pick(6, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    model_reset();
    check_all_zero("rst_reveal");
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    pick(6, 1'b1);
    chk("after_rst_go", 32'(go), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
